retire_store_buffer_mp: RTL and testbench

RETIRE_STORE_BUFFER_MP -- requirements
Module: retire_store_buffer_mp

---
 rtl/retire_store_buffer_mp_pkg.sv | 48 ++++
 rtl/retire_store_buffer_mp_if.sv | 39 +++
 rtl/retire_store_buffer_mp_fwd_match.sv | 24 ++
 rtl/retire_store_buffer_mp.sv | 141 ++++++++++++++
 tb/tb_retire_store_buffer_mp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/retire_store_buffer_mp_pkg.sv
// Shared types for the retire store buffer: the store entry packet,
// memory access size encodings and the byte-lane helpers used by the
// drain path and the load forwarding logic.
package retire_store_buffer_mp_pkg;

    localparam int LQ_IDX_W = 4;

    typedef enum logic [2:0] {
        MEM_BYTE = 3'd0,
        MEM_HALF = 3'd1,
        MEM_WORD = 3'd2
    } mem_size_e;

    typedef struct packed {
        logic [31:0]         addr;
        logic [31:0]         value;
        mem_size_e           mem_size;
        logic [LQ_IDX_W-1:0] lq_idx;
    } SQ_ENTRY_PACKET;

    // Bytes touched inside the 32-bit word; spans running past byte 3 are clipped.
    function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [2:0] size);
        logic [3:0] base;
        case (size)
            3'd0:    base = 4'b0001;
            3'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    // Store value is right-justified from its own offset; re-justify it to the load offset.
    function automatic logic [31:0] fwd_value(input SQ_ENTRY_PACKET st,
                                              input logic [31:0] ld_addr,
                                              input logic [2:0] ld_size);
        logic [31:0] word;
        logic [31:0] keep;
        word = st.value << (8 * st.addr[1:0]);
        word = word >> (8 * ld_addr[1:0]);
        case (ld_size)
            3'd0:    keep = 32'h0000_00FF;
            3'd1:    keep = 32'h0000_FFFF;
            default: keep = 32'hFFFF_FFFF;
        endcase
        return word & keep;
    endfunction

endpackage

// File: rtl/retire_store_buffer_mp_if.sv
// Bus bundle between the core (retire + load ports + D-cache side) and the
// retire store buffer. master = core/cache side, slave = the buffer.
interface retire_store_buffer_mp_if #(
    parameter int DEPTH    = 32,
    parameter int WR_PORTS = 2,
    parameter int LD_PORTS = 2
);
    import retire_store_buffer_mp_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WR_PORTS-1:0]                 wr_en;
    SQ_ENTRY_PACKET [WR_PORTS-1:0]       wr_data;
    logic                                wr_ready;
    logic                                mem_req_valid;
    SQ_ENTRY_PACKET                      mem_req_data;
    logic                                mem_req_ready;
    logic [LD_PORTS-1:0][31:0]           ld_addr;
    logic [LD_PORTS-1:0][2:0]            ld_size;
    logic [LD_PORTS-1:0]                 ld_fwd_valid;
    logic [LD_PORTS-1:0][31:0]           ld_fwd_value;
    logic [LD_PORTS-1:0]                 ld_fwd_partial;
    logic [CW-1:0]                       count;
    logic                                empty;
    logic                                full;

    modport master (
        output wr_en, wr_data, mem_req_ready, ld_addr, ld_size,
        input  wr_ready, mem_req_valid, mem_req_data,
        input  ld_fwd_valid, ld_fwd_value, ld_fwd_partial, count, empty, full
    );

    modport slave (
        input  wr_en, wr_data, mem_req_ready, ld_addr, ld_size,
        output wr_ready, mem_req_valid, mem_req_data,
        output ld_fwd_valid, ld_fwd_value, ld_fwd_partial, count, empty, full
    );

endinterface

// File: rtl/retire_store_buffer_mp_fwd_match.sv
// Per-entry/per-load comparator: same word and overlapping bytes, and
// whether the store's bytes fully cover the load's bytes.
module rsb_fwd_match (
    input  logic        i_valid,
    input  logic [31:0] i_st_addr,
    input  logic [2:0]  i_st_size,
    input  logic [31:0] i_ld_addr,
    input  logic [2:0]  i_ld_size,
    output logic        o_overlap,
    output logic        o_cover
);
    import retire_store_buffer_mp_pkg::*;

    logic [3:0] w_st_mask;
    logic [3:0] w_ld_mask;
    logic       w_word_eq;

    assign w_st_mask = byte_mask(i_st_addr[1:0], i_st_size);
    assign w_ld_mask = byte_mask(i_ld_addr[1:0], i_ld_size);
    assign w_word_eq = (i_st_addr[31:2] == i_ld_addr[31:2]);
    assign o_overlap = i_valid && w_word_eq && ((w_st_mask & w_ld_mask) != 4'b0000);
    assign o_cover   = o_overlap && ((w_ld_mask & ~w_st_mask) == 4'b0000);

endmodule

// File: rtl/retire_store_buffer_mp.sv
// Retire store buffer: multi-port in-order fill from retirement, single
// drain port to the D-cache, and store-to-load forwarding lookup.
// Build option: define RSB_FWD_EN to forward data; without it any
// overlapping pending store only raises ld_fwd_partial (load stalls).
module retire_store_buffer_mp #(
    parameter int DEPTH    = 32,
    parameter int WR_PORTS = 2,
    parameter int LD_PORTS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    retire_store_buffer_mp_if.slave  bus
);
    import retire_store_buffer_mp_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    SQ_ENTRY_PACKET      r_mem [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic [CW-1:0]       w_free;
    logic                w_wr_ready;
    logic                w_do_write;
    logic                w_pop;
    logic                w_mem_req_valid;
    logic [CW-1:0]       w_push_cnt;
    logic [AW-1:0]       w_slot [WR_PORTS];
    logic [DEPTH-1:0]    w_overlap [LD_PORTS];
    logic [DEPTH-1:0]    w_cover [LD_PORTS];

    // Compact the asserted write ports into consecutive slots starting at tail.
    always_comb begin
        w_push_cnt = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            w_slot[p] = r_tail + w_push_cnt[AW-1:0];
            if (bus.wr_en[p]) begin
                w_push_cnt = w_push_cnt + CW'(1);
            end
        end
    end

    assign w_free          = CW'(DEPTH) - r_count;
    assign w_wr_ready      = (w_free >= CW'(WR_PORTS));
    assign w_do_write      = (bus.wr_en != '0) && w_wr_ready;
    assign w_mem_req_valid = (r_count != '0);
    assign w_pop           = w_mem_req_valid && bus.mem_req_ready;

    // Pointer, occupancy and storage update; writes while not ready are dropped whole.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + AW'(1);
            end
            if (w_do_write) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (bus.wr_en[p]) begin
                        r_mem[w_slot[p]]   <= bus.wr_data[p];
                        r_valid[w_slot[p]] <= 1'b1;
                    end
                end
                r_tail <= r_tail + w_push_cnt[AW-1:0];
            end
            r_count <= r_count + (w_do_write ? w_push_cnt : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
        end
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_req_data  = w_mem_req_valid ? r_mem[r_head] : '0;
    assign bus.count         = r_count;
    assign bus.empty         = (r_count == '0);
    assign bus.full          = (r_count == CW'(DEPTH));

    for (genvar l = 0; l < LD_PORTS; l++) begin : g_ld
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            rsb_fwd_match u_match (
                .i_valid   (r_valid[e]),
                .i_st_addr (r_mem[e].addr),
                .i_st_size (r_mem[e].mem_size),
                .i_ld_addr (bus.ld_addr[l]),
                .i_ld_size (bus.ld_size[l]),
                .o_overlap (w_overlap[l][e]),
                .o_cover   (w_cover[l][e])
            );
        end
    end

`ifdef RSB_FWD_EN
    logic              w_hit [LD_PORTS];
    logic [AW-1:0]     w_sel [LD_PORTS];

    // Walk oldest to youngest so the last overlapping entry (nearest tail) decides.
    always_comb begin
        bus.ld_fwd_valid   = '0;
        bus.ld_fwd_partial = '0;
        bus.ld_fwd_value   = '0;
        for (int l = 0; l < LD_PORTS; l++) begin
            w_hit[l] = 1'b0;
            w_sel[l] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_overlap[l][r_head + AW'(i)]) begin
                    w_hit[l] = 1'b1;
                    w_sel[l] = r_head + AW'(i);
                end
            end
            if (w_hit[l]) begin
                if (w_cover[l][w_sel[l]]) begin
                    bus.ld_fwd_valid[l] = 1'b1;
                    bus.ld_fwd_value[l] = fwd_value(r_mem[w_sel[l]], bus.ld_addr[l], bus.ld_size[l]);
                end else begin
                    bus.ld_fwd_partial[l] = 1'b1;
                end
            end
        end
    end
`else
    logic [LD_PORTS-1:0] w_unused_cover;

    // Without forwarding, any overlapping pending store stalls the load.
    always_comb begin
        bus.ld_fwd_valid   = '0;
        bus.ld_fwd_value   = '0;
        bus.ld_fwd_partial = '0;
        for (int l = 0; l < LD_PORTS; l++) begin
            bus.ld_fwd_partial[l] = (w_overlap[l] != '0);
            w_unused_cover[l]     = ^w_cover[l];
        end
    end
`endif

endmodule

// File: tb/tb_retire_store_buffer_mp.sv
// Directed self-checking bench for retire_store_buffer_mp (DEPTH=32,
// two write ports, two load ports). Expectations follow RSB_FWD_EN.
module tb_retire_store_buffer_mp;
    import retire_store_buffer_mp_pkg::*;

    localparam int DEPTH    = 32;
    localparam int WR_PORTS = 2;
    localparam int LD_PORTS = 2;
`ifdef RSB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    int illegalCount = 0;
    SQ_ENTRY_PACKET junk;

    retire_store_buffer_mp_if #(.DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .LD_PORTS(LD_PORTS)) bus ();

    retire_store_buffer_mp #(.DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .LD_PORTS(LD_PORTS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, posedge every 10 time units.
    always #5 clock = ~clock;

    function automatic SQ_ENTRY_PACKET mkStore(input logic [31:0] a, input logic [31:0] v, input mem_size_e s);
        SQ_ENTRY_PACKET e;
        e.addr     = a;
        e.value    = v;
        e.mem_size = s;
        e.lq_idx   = a[5:2];
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFwd(input string tag, input int p, input logic expValid,
                            input logic [31:0] expValue, input logic expPartial);
        checkOutput({tag, ".valid"},   32'(bus.ld_fwd_valid[p]),   32'(expValid));
        checkOutput({tag, ".value"},   bus.ld_fwd_value[p],        expValue);
        checkOutput({tag, ".partial"}, 32'(bus.ld_fwd_partial[p]), 32'(expPartial));
    endtask

    // Drive one cycle of retire/drain inputs, then return to idle just after the edge.
    task automatic applyStimulus(input logic [1:0] en, input SQ_ENTRY_PACKET d0,
                                 input SQ_ENTRY_PACKET d1, input logic rdy);
        bus.wr_en         = en;
        bus.wr_data[0]    = d0;
        bus.wr_data[1]    = d1;
        bus.mem_req_ready = rdy;
        #1;
        if ((en != 2'b00) && !bus.wr_ready) begin
            illegalCount++;
            $display("[TB] note: write attempted while wr_ready low, entries dropped");
        end
        @(posedge clock);
        #1;
        bus.wr_en         = '0;
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic setLoads(input logic [31:0] a0, input logic [2:0] s0,
                            input logic [31:0] a1, input logic [2:0] s1);
        bus.ld_addr[0] = a0;
        bus.ld_size[0] = s0;
        bus.ld_addr[1] = a1;
        bus.ld_size[1] = s1;
        #1;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        junk              = mkStore(32'hFFF0, 32'hDEAD_0000, MEM_WORD);
        reset             = 1'b1;
        bus.wr_en         = '0;
        bus.wr_data       = '0;
        bus.mem_req_ready = 1'b0;
        bus.ld_addr       = '0;
        bus.ld_size       = '0;

        // Reset state
        @(posedge clock); #1;
        @(posedge clock); #1;
        setLoads(32'h100, MEM_WORD, 32'h104, MEM_BYTE);
        checkOutput("rst.empty",    32'(bus.empty),         32'd1);
        checkOutput("rst.full",     32'(bus.full),          32'd0);
        checkOutput("rst.wr_ready", 32'(bus.wr_ready),      32'd1);
        checkOutput("rst.valid",    32'(bus.mem_req_valid), 32'd0);
        checkOutput("rst.data",     bus.mem_req_data.addr,  32'd0);
        checkOutput("rst.count",    32'(bus.count),         32'd0);
        checkFwd("rst.ld0", 0, 1'b0, 32'h0, 1'b0);
        checkFwd("rst.ld1", 1, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;

        // Two-port write then drain in order
        applyStimulus(2'b11, mkStore(32'h100, 32'h1111_1111, MEM_WORD),
                             mkStore(32'h104, 32'h2222_2222, MEM_WORD), 1'b1);
        checkOutput("wr2.valid", 32'(bus.mem_req_valid), 32'd1);
        checkOutput("wr2.addr",  bus.mem_req_data.addr,  32'h100);
        checkOutput("wr2.value", bus.mem_req_data.value, 32'h1111_1111);
        checkOutput("wr2.count", 32'(bus.count),         32'd2);
        applyStimulus(2'b00, junk, junk, 1'b1);
        checkOutput("pop1.addr",  bus.mem_req_data.addr, 32'h104);
        checkOutput("pop1.count", 32'(bus.count),        32'd1);
        applyStimulus(2'b00, junk, junk, 1'b1);
        checkOutput("pop2.empty", 32'(bus.empty),         32'd1);
        checkOutput("pop2.valid", 32'(bus.mem_req_valid), 32'd0);

        // Forwarding: word store then younger byte store into the same word
        applyStimulus(2'b11, mkStore(32'h200, 32'hAABB_CCDD, MEM_WORD),
                             mkStore(32'h201, 32'h0000_0011, MEM_BYTE), 1'b0);
        setLoads(32'h201, MEM_BYTE, 32'h200, MEM_WORD);
        checkFwd("fwd.byte201", 0, FWD, FWD ? 32'h11 : 32'h0, !FWD);
        checkFwd("fwd.word200", 1, 1'b0, 32'h0, 1'b1);
        setLoads(32'h203, MEM_BYTE, 32'h202, MEM_HALF);
        checkFwd("fwd.byte203", 0, FWD, FWD ? 32'hAA : 32'h0, !FWD);
        checkFwd("fwd.half202", 1, FWD, FWD ? 32'hAABB : 32'h0, !FWD);
        setLoads(32'h208, MEM_BYTE, 32'h200, MEM_HALF);
        checkFwd("fwd.miss208", 0, 1'b0, 32'h0, 1'b0);
        checkFwd("fwd.half200", 1, 1'b0, 32'h0, 1'b1);
        applyStimulus(2'b00, junk, junk, 1'b1);
        applyStimulus(2'b00, junk, junk, 1'b1);
        setLoads(32'h201, MEM_BYTE, 32'h200, MEM_WORD);
        checkFwd("fwd.drained0", 0, 1'b0, 32'h0, 1'b0);
        checkFwd("fwd.drained1", 1, 1'b0, 32'h0, 1'b0);

        // Misaligned half clipped at word end, plus pending word store at 0x300
        applyStimulus(2'b11, mkStore(32'h403, 32'h0000_5566, MEM_HALF),
                             mkStore(32'h300, 32'hDEAD_BEEF, MEM_WORD), 1'b0);
        setLoads(32'h403, MEM_BYTE, 32'h404, MEM_BYTE);
        checkFwd("clip.byte403", 0, FWD, FWD ? 32'h66 : 32'h0, !FWD);
        checkFwd("clip.byte404", 1, 1'b0, 32'h0, 1'b0);
        setLoads(32'h208, MEM_BYTE, 32'h302, MEM_HALF);
        checkFwd("st300.half302", 1, FWD, FWD ? 32'hDEAD : 32'h0, !FWD);
        applyStimulus(2'b00, junk, junk, 1'b1);
        applyStimulus(2'b00, junk, junk, 1'b1);
        setLoads(32'h403, MEM_BYTE, 32'h302, MEM_HALF);
        checkFwd("st300.drained", 1, 1'b0, 32'h0, 1'b0);
        checkFwd("clip.drained",  0, 1'b0, 32'h0, 1'b0);
        checkOutput("fwd.count", 32'(bus.count), 32'd0);

        // Fill to 31 with the drain stalled
        for (int k = 0; k < 15; k++) begin
            applyStimulus(2'b11, mkStore(32'h1000 + 32'(8 * k), 32'(k), MEM_WORD),
                                 mkStore(32'h1004 + 32'(8 * k), 32'(k + 100), MEM_WORD), 1'b0);
        end
        checkOutput("fill30.count",    32'(bus.count),    32'd30);
        checkOutput("fill30.wr_ready", 32'(bus.wr_ready), 32'd1);
        applyStimulus(2'b01, mkStore(32'h1078, 32'h78, MEM_WORD), junk, 1'b0);
        checkOutput("fill31.count",    32'(bus.count),    32'd31);
        checkOutput("fill31.wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("fill31.full",     32'(bus.full),     32'd0);
        applyStimulus(2'b11, mkStore(32'hBAD0, 32'h0, MEM_WORD), mkStore(32'hBAD4, 32'h0, MEM_WORD), 1'b0);
        checkOutput("illegal1.seen",  32'(illegalCount),      32'd1);
        checkOutput("illegal1.count", 32'(bus.count),         32'd31);
        checkOutput("illegal1.head",  bus.mem_req_data.addr,  32'h1000);
        applyStimulus(2'b11, mkStore(32'hBAD8, 32'h0, MEM_WORD), mkStore(32'hBADC, 32'h0, MEM_WORD), 1'b1);
        checkOutput("illegal2.seen",  32'(illegalCount), 32'd2);
        checkOutput("illegal2.count", 32'(bus.count),    32'd30);
        for (int j = 0; j < 30; j++) begin
            checkOutput("drain.order", bus.mem_req_data.addr, 32'h1004 + 32'(4 * j));
            applyStimulus(2'b00, junk, junk, 1'b1);
        end
        checkOutput("drain.empty", 32'(bus.empty), 32'd1);

        // Pointer wrap with alternating single-port writes and continuous drain
        for (int c = 0; c < 40; c++) begin
            if ((c % 2) == 0) begin
                applyStimulus(2'b01, mkStore(32'h2000 + 32'(4 * c), 32'(c), MEM_WORD), junk, 1'b1);
            end else begin
                applyStimulus(2'b10, junk, mkStore(32'h2000 + 32'(4 * c), 32'(c), MEM_WORD), 1'b1);
            end
            checkOutput("wrap.count", 32'(bus.count),        32'd1);
            checkOutput("wrap.order", bus.mem_req_data.addr, 32'h2000 + 32'(4 * c));
        end
        applyStimulus(2'b00, junk, junk, 1'b1);
        checkOutput("wrap.empty", 32'(bus.empty), 32'd1);

        // Reset while a request is offered, with concurrent write and ready
        applyStimulus(2'b11, mkStore(32'h600, 32'h6, MEM_WORD), mkStore(32'h604, 32'h7, MEM_WORD), 1'b0);
        checkOutput("rstmid.pre_valid", 32'(bus.mem_req_valid), 32'd1);
        reset = 1'b1;
        applyStimulus(2'b11, mkStore(32'h700, 32'h8, MEM_WORD), mkStore(32'h704, 32'h9, MEM_WORD), 1'b1);
        checkOutput("rstmid.valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("rstmid.count", 32'(bus.count),         32'd0);
        checkOutput("rstmid.empty", 32'(bus.empty),         32'd1);
        checkOutput("rstmid.data",  bus.mem_req_data.addr,  32'd0);
        reset = 1'b0;
        applyStimulus(2'b00, junk, junk, 1'b0);
        checkOutput("rstmid.after", 32'(bus.empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
